// File: rtl/counter_arbiter.sv
// counter_arbiter: round-robin arbiter sharing one up/down counter among N_REQ requesters
// Define COUNTER_ARB_SATURATE_EN to saturate at the ends instead of wrapping.
module counter_arbiter #(
  parameter int BITS  = 8,
  parameter int N_REQ = 4,
  localparam int IDW  = $clog2(N_REQ)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_clear,
  input  logic [N_REQ-1:0] i_req,
  input  logic [N_REQ-1:0] i_inc_dec,
  output logic [N_REQ-1:0] o_grant,
  output logic [IDW-1:0]   o_grant_id,
  output logic [BITS-1:0]  o_value,
  output logic             o_wrap
);
  logic [IDW-1:0]   ptr, win;
  logic [N_REQ-1:0] elig;
  logic             found, op, edge_hit;
  logic [BITS-1:0]  nxt;
  assign elig = i_req & ~o_grant;
  // Scanning offsets high-to-low leaves the nearest eligible index after ptr as the winner.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (elig[(int'(ptr) + k) % N_REQ]) begin
        found = 1'b1;
        win   = IDW'((int'(ptr) + k) % N_REQ);
      end
    end
  end
  assign op       = i_inc_dec[win];
  assign edge_hit = op ? (o_value == '1) : (o_value == '0);
`ifdef COUNTER_ARB_SATURATE_EN
  assign nxt = edge_hit ? o_value : (op ? o_value + 1'b1 : o_value - 1'b1);
`else
  assign nxt = op ? o_value + 1'b1 : o_value - 1'b1;
`endif
  always_ff @(posedge clock) begin
    if (reset) begin
      o_value    <= '0;
      o_grant    <= '0;
      o_grant_id <= '0;
      o_wrap     <= 1'b0;
      ptr        <= '0;
    end else if (i_clear) begin
      o_value <= '0;
      o_grant <= '0;
      o_wrap  <= 1'b0;
    end else if (found) begin
      o_value    <= nxt;
      o_grant    <= N_REQ'(1) << win;
      o_grant_id <= win;
      o_wrap     <= edge_hit;
      ptr        <= (win == IDW'(N_REQ - 1)) ? '0 : win + 1'b1;
    end else begin
      o_grant <= '0;
      o_wrap  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_counter_arbiter.sv
// tb_counter_arbiter: scoreboard bench for counter_arbiter (N_REQ=4, BITS=8)
module tb_counter_arbiter;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       i_clear = 1'b0;
  logic [3:0] i_req = '0;
  logic [3:0] i_inc_dec = '0;
  logic [3:0] o_grant;
  logic [1:0] o_grant_id;
  logic [7:0] o_value;
  logic       o_wrap;

  counter_arbiter #(.BITS(8), .N_REQ(4)) dut (
    .clock(clock), .reset(reset), .i_clear(i_clear), .i_req(i_req),
    .i_inc_dec(i_inc_dec), .o_grant(o_grant), .o_grant_id(o_grant_id),
    .o_value(o_value), .o_wrap(o_wrap)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] id;
    logic [7:0] value;
    logic       wrap;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   m_ptr = 0;
  logic [7:0] m_val = '0;
  logic [3:0] m_grant = '0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic rst, input logic clr, input logic [3:0] req, input logic [3:0] inc);
    exp_t e, o;
    int   w;
    reset = rst; i_clear = clr; i_req = req; i_inc_dec = inc;
    e = '0;
    if (rst) begin
      m_ptr = 0; m_val = 0; m_grant = 0;
    end else if (clr) begin
      m_val = 0; m_grant = 0;
    end else begin
      w = -1;
      for (int k = 0; k < 4 && w < 0; k++)
        if (req[(m_ptr + k) % 4] && !m_grant[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
      if (w < 0) m_grant = 0;
      else begin
        m_grant = 4'b1 << w;
        e.id = 2'(w);
        if (inc[w]) begin
          e.wrap = (m_val == 8'hff);
`ifdef COUNTER_ARB_SATURATE_EN
          if (!e.wrap) m_val = m_val + 1;
`else
          m_val = m_val + 1;
`endif
        end else begin
          e.wrap = (m_val == 8'h00);
`ifdef COUNTER_ARB_SATURATE_EN
          if (!e.wrap) m_val = m_val - 1;
`else
          m_val = m_val - 1;
`endif
        end
        m_ptr = (w + 1) % 4;
      end
    end
    e.grant = m_grant;
    e.value = m_val;
    q.push_back(e);
    @(posedge clock);
    #1;
    o = q.pop_front();
    chk("grant", 8'(o_grant), 8'(o.grant));
    chk("value", o_value, o.value);
    chk("wrap", 8'(o_wrap), 8'(o.wrap));
    if (o.grant != 0) chk("grant_id", 8'(o_grant_id), 8'(o.id));
  endtask

  initial begin
    step(1, 0, 4'b0000, 4'b0000);
    repeat (5) step(0, 0, 4'b0000, 4'b0000);
    repeat (8) step(0, 0, 4'b0001, 4'b1111);
    chk("req0_held_value", o_value, 8'd4);
    repeat (8) step(0, 0, 4'b1111, 4'b1111);
    step(0, 1, 4'b0000, 4'b0000);
    repeat (5) step(0, 0, 4'b0001, 4'b1111);
    chk("value_three", o_value, 8'd3);
    step(0, 1, 4'b0100, 4'b0000);
    chk("clear_value", o_value, 8'd0);
    chk("clear_grant", 8'(o_grant), 8'd0);
    step(0, 0, 4'b0100, 4'b0000);
    chk("dec_grant", 8'(o_grant), 8'b0100);
    chk("dec_wrap", 8'(o_wrap), 8'd1);
`ifdef COUNTER_ARB_SATURATE_EN
    chk("dec_value", o_value, 8'd0);
`else
    chk("dec_value", o_value, 8'd255);
`endif
    repeat (60) step(0, ($urandom_range(0, 15) == 0), 4'($urandom), 4'($urandom));
    step(0, 1, 4'b0000, 4'b0000);
    repeat (510) step(0, 0, 4'b0001, 4'b0001);
    chk("at_max", o_value, 8'd255);
    step(0, 0, 4'b0010, 4'b0010);
    chk("max_grant", 8'(o_grant), 8'b0010);
    chk("max_wrap", 8'(o_wrap), 8'd1);
`ifdef COUNTER_ARB_SATURATE_EN
    chk("max_value", o_value, 8'd255);
`else
    chk("max_value", o_value, 8'd0);
`endif
    step(0, 0, 4'b1000, 4'b1000);
    step(1, 0, 4'b1000, 4'b1000);
    chk("reset_grant", 8'(o_grant), 8'd0);
    chk("reset_value", o_value, 8'd0);
    step(0, 0, 4'b1111, 4'b1111);
    chk("reset_ptr", 8'(o_grant_id), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
